// File: rtl/sonar_pkg.sv
// Shared types for the sonar ping sequencer: ping FSM states, echo tracker
// states, the echo record layout and the sweep angle helper.
package sonar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    BLANK  = 2'd2,
    LISTEN = 2'd3
  } ping_state_t;

  typedef enum logic {
    TRK_ARMED = 1'b0,
    TRK_OPEN  = 1'b1
  } trk_state_t;

  // Echo record at full-size field widths. The sequencer carries the fields
  // at its parameterised widths; this is the container used downstream.
  typedef struct packed {
    logic [31:0] tof;
    logic [31:0] peak;
    logic [7:0]  index;
    logic [15:0] angle;
  } echo_rec_t;

  function automatic int sweep_angle(input int start, input int step, input int idx);
    return start + idx * step;
  endfunction

endpackage

// File: rtl/sonar_ping_sequencer_if.sv
// Echo report bus: one strobed record per detected echo plus the
// period-end "nothing heard" pulse.
interface sonar_ping_sequencer_if #(
  parameter int TW = 24,
  parameter int SW = 16,
  parameter int AW = 8,
  parameter int IW = 2
);
  import sonar_pkg::*;

  logic                 valid;
  logic [IW-1:0]        index;
  logic [TW-1:0]        tof;
  logic [SW-1:0]        peak;
  logic signed [AW-1:0] angle;
  logic                 no_echo;

  modport master (output valid, index, tof, peak, angle, no_echo);
  modport slave  (input  valid, index, tof, peak, angle, no_echo);
endinterface

// File: rtl/echo_tracker.sv
// Hysteresis echo detector: opens on a crossing above threshold, tracks the
// peak, closes at or below half threshold. An echo still open when the ping
// is flushed is emitted with its current peak. At most MAX_ECHOES per ping.
module echo_tracker
  import sonar_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ANGLE_WIDTH  = 8,
  parameter int TW           = 24,
  parameter int MAX_ECHOES   = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic [SAMPLE_WIDTH-1:0]       sample,
  input  logic                          valid,
  input  logic [SAMPLE_WIDTH-1:0]       threshold,
  input  logic                          window,
  input  logic                          flush,
  input  logic                          ping_start,
  input  logic [TW-1:0]                 timer,
  input  logic signed [ANGLE_WIDTH-1:0] angle,
  sonar_ping_sequencer_if.master        echo
);

  localparam int CW = $clog2(MAX_ECHOES + 1);
  localparam int EW = $clog2(MAX_ECHOES);

  trk_state_t              trk, trk_nxt;
  logic [CW-1:0]           count, count_nxt;
  logic [TW-1:0]           tof, tof_nxt;
  logic [SAMPLE_WIDTH-1:0] peak, peak_nxt;
  logic                    done, live, emit;

  // Hysteresis and peak hold; flush forces out an echo left open at period end.
  always_comb begin
    trk_nxt  = trk;
    tof_nxt  = tof;
    peak_nxt = peak;
    emit     = 1'b0;
    live     = window && valid && !done && (count < CW'(MAX_ECHOES));
    if (live) begin
      if (trk == TRK_ARMED) begin
        if (sample > threshold) begin
          trk_nxt  = TRK_OPEN;
          tof_nxt  = timer;
          peak_nxt = sample;
        end
      end else if (sample <= (threshold >> 1)) begin
        emit    = 1'b1;
        trk_nxt = TRK_ARMED;
      end else if (sample > peak) begin
        peak_nxt = sample;
      end
    end
    if (flush && (trk_nxt == TRK_OPEN) && !emit) begin
      emit    = 1'b1;
      trk_nxt = TRK_ARMED;
    end
    count_nxt = emit ? count + CW'(1) : count;
  end

  // Tracker state and registered echo record; fields hold between strobes.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      trk          <= TRK_ARMED;
      count        <= '0;
      tof          <= '0;
      peak         <= '0;
      done         <= 1'b0;
      echo.valid   <= 1'b0;
      echo.index   <= '0;
      echo.tof     <= '0;
      echo.peak    <= '0;
      echo.angle   <= '0;
      echo.no_echo <= 1'b0;
    end else if (ping_start) begin
      trk          <= TRK_ARMED;
      count        <= '0;
      done         <= 1'b0;
      echo.valid   <= 1'b0;
      echo.no_echo <= 1'b0;
    end else begin
      trk          <= trk_nxt;
      tof          <= tof_nxt;
      peak         <= peak_nxt;
      count        <= count_nxt;
      done         <= done | flush;
      echo.valid   <= emit;
      echo.no_echo <= flush && (count_nxt == '0);
      if (emit) begin
        echo.index <= count[EW-1:0];
        echo.tof   <= tof_nxt;
        echo.peak  <= peak_nxt;
        echo.angle <= angle;
      end
    end
  end

endmodule

// File: rtl/sonar_ping_sequencer.sv
// Ping sequencer: schedules burst / blanking / listen windows per period,
// steps or holds the beam angle, and hands the listen window to the tracker.
//
// state  | meaning
// IDLE   | not pinging, waiting for enable_in
// BURST  | transmit gate open, timer 0 .. BURST_CYCLES-1
// BLANK  | ringdown blanking, receive ignored
// LISTEN | echo window until the period end
module sonar_ping_sequencer
  import sonar_pkg::*;
#(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int BLANK_CYCLES  = 65536,
  parameter int ANGLE_WIDTH   = 8,
  parameter int NUM_ANGLES    = 7,
  parameter int ANGLE_START   = -30,
  parameter int ANGLE_STEP    = 10,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int MAX_ECHOES    = 4,
  parameter int TW            = $clog2(PERIOD_CYCLES)
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          enable_in,
  input  logic                          sweep_mode_in,
  input  logic signed [ANGLE_WIDTH-1:0] fixed_angle_in,
  input  logic [SAMPLE_WIDTH-1:0]       threshold_in,
  input  logic [SAMPLE_WIDTH-1:0]       sample_in,
  input  logic                          sample_valid_in,
  output logic signed [ANGLE_WIDTH-1:0] angle_out,
  output logic                          burst_start_out,
  output logic                          burst_active_out,
  output logic                          listening_out,
  output logic                          echo_valid_out,
  output logic [$clog2(MAX_ECHOES)-1:0] echo_index_out,
  output logic [TW-1:0]                 echo_time_out,
  output logic [SAMPLE_WIDTH-1:0]       echo_peak_out,
  output logic [ANGLE_WIDTH-1:0]        echo_angle_out,
  output logic                          no_echo_out,
  output logic                          scan_done_out
);

  localparam int IW = (NUM_ANGLES > 1) ? $clog2(NUM_ANGLES) : 1;
  localparam int EW = $clog2(MAX_ECHOES);
  localparam logic [TW-1:0] BURST_END = TW'(BURST_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [TW-1:0] PRE_END   = TW'(PERIOD_CYCLES - 2);
  localparam logic [TW-1:0] LAST      = TW'(PERIOD_CYCLES - 1);

  ping_state_t                   state, state_nxt;
  logic [TW-1:0]                 timer;
  logic [IW-1:0]                 idx, idx_adv, idx_start;
  logic                          sweep_lat;
  logic                          period_end, pre_end, start_ping;
  logic signed [ANGLE_WIDTH-1:0] angle_start;

  sonar_ping_sequencer_if #(.TW(TW), .SW(SAMPLE_WIDTH), .AW(ANGLE_WIDTH), .IW(EW)) echo_bus ();

  assign period_end = (state == LISTEN) && (timer == LAST);
  // Period-end pulses are registered, so they are launched one cycle early.
  assign pre_end    = (state == LISTEN) && (timer == PRE_END);

  // Next state; a new ping starts from IDLE or straight from the period end.
  always_comb begin
    state_nxt  = state;
    start_ping = 1'b0;
    case (state)
      IDLE: begin
        if (enable_in) begin
          state_nxt  = BURST;
          start_ping = 1'b1;
        end
      end
      BURST:  if (timer == BURST_END) state_nxt = BLANK;
      BLANK:  if (timer == BLANK_END) state_nxt = LISTEN;
      LISTEN: begin
        if (period_end) begin
          if (enable_in) begin
            state_nxt  = BURST;
            start_ping = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep index: advance at a sweep ping's end, restart when sweep is freshly entered.
  always_comb begin
    idx_adv = idx;
    if (period_end && sweep_lat)
      idx_adv = (idx == IW'(NUM_ANGLES - 1)) ? '0 : idx + IW'(1);
    idx_start = (sweep_mode_in && !(sweep_lat && (state == LISTEN))) ? '0 : idx_adv;
    angle_start = sweep_mode_in
                ? ANGLE_WIDTH'(sweep_angle(ANGLE_START, ANGLE_STEP, int'(idx_start)))
                : fixed_angle_in;
  end

  // State, timer, per-ping latches and registered window/pulse outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      timer            <= '0;
      idx              <= '0;
      sweep_lat        <= 1'b0;
      angle_out        <= '0;
      burst_start_out  <= 1'b0;
      burst_active_out <= 1'b0;
      listening_out    <= 1'b0;
      scan_done_out    <= 1'b0;
    end else begin
      state            <= state_nxt;
      burst_start_out  <= start_ping;
      burst_active_out <= (state_nxt == BURST);
      listening_out    <= (state_nxt == LISTEN);
      scan_done_out    <= pre_end && sweep_lat && (idx == IW'(NUM_ANGLES - 1));
      if (start_ping || (state_nxt == IDLE)) timer <= '0;
      else                                   timer <= timer + TW'(1);
      if (start_ping) begin
        idx       <= idx_start;
        sweep_lat <= sweep_mode_in;
        angle_out <= angle_start;
      end else begin
        idx <= idx_adv;
      end
    end
  end

  echo_tracker #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .ANGLE_WIDTH  (ANGLE_WIDTH),
    .TW           (TW),
    .MAX_ECHOES   (MAX_ECHOES)
  ) u_echo_tracker (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sample     (sample_in),
    .valid      (sample_valid_in),
    .threshold  (threshold_in),
    .window     (listening_out),
    .flush      (pre_end),
    .ping_start (start_ping),
    .timer      (timer),
    .angle      (angle_out),
    .echo       (echo_bus.master)
  );

  assign echo_valid_out = echo_bus.valid;
  assign echo_index_out = echo_bus.index;
  assign echo_time_out  = echo_bus.tof;
  assign echo_peak_out  = echo_bus.peak;
  assign echo_angle_out = echo_bus.angle;
  assign no_echo_out    = echo_bus.no_echo;

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Directed bench for the sonar ping sequencer with a 64-clock period.
module tb_sonar_ping_sequencer;
  import sonar_pkg::*;

  localparam int P = 64;

  logic              clk_in = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable_in = 1'b0;
  logic              sweep_mode_in = 1'b0;
  logic signed [7:0] fixed_angle_in = '0;
  logic [15:0]       threshold_in = '0;
  logic [15:0]       sample_in = '0;
  logic              sample_valid_in = 1'b0;
  logic signed [7:0] angle_out;
  logic              burst_start_out, burst_active_out, listening_out;
  logic              echo_valid_out, no_echo_out, scan_done_out;
  logic [0:0]        echo_index_out;
  logic [5:0]        echo_time_out;
  logic [15:0]       echo_peak_out;
  logic [7:0]        echo_angle_out;

  integer n_checks = 0;
  integer n_fail = 0;
  int     tcur = 0;

  sonar_ping_sequencer_if #(.TW(6), .SW(16), .AW(8), .IW(1)) mon ();

  sonar_ping_sequencer #(
    .PERIOD_CYCLES (64),
    .BURST_CYCLES  (8),
    .BLANK_CYCLES  (4),
    .ANGLE_WIDTH   (8),
    .NUM_ANGLES    (4),
    .ANGLE_START   (-30),
    .ANGLE_STEP    (20),
    .SAMPLE_WIDTH  (16),
    .MAX_ECHOES    (2)
  ) dut (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .enable_in        (enable_in),
    .sweep_mode_in    (sweep_mode_in),
    .fixed_angle_in   (fixed_angle_in),
    .threshold_in     (threshold_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .angle_out        (angle_out),
    .burst_start_out  (burst_start_out),
    .burst_active_out (burst_active_out),
    .listening_out    (listening_out),
    .echo_valid_out   (echo_valid_out),
    .echo_index_out   (echo_index_out),
    .echo_time_out    (echo_time_out),
    .echo_peak_out    (echo_peak_out),
    .echo_angle_out   (echo_angle_out),
    .no_echo_out      (no_echo_out),
    .scan_done_out    (scan_done_out)
  );

  assign mon.valid   = echo_valid_out;
  assign mon.index   = echo_index_out;
  assign mon.tof     = echo_time_out;
  assign mon.peak    = echo_peak_out;
  assign mon.angle   = echo_angle_out;
  assign mon.no_echo = no_echo_out;

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input integer got, input integer exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_echo(input string tag, input echo_rec_t e);
    chk({tag, "_valid"}, mon.valid, 1);
    chk({tag, "_time"},  mon.tof, e.tof);
    chk({tag, "_peak"},  mon.peak, e.peak);
    chk({tag, "_index"}, mon.index, e.index);
    chk({tag, "_angle"}, mon.angle, $signed(e.angle));
  endtask

  task automatic tick();
    @(negedge clk_in);
    tcur = (tcur + 1) % P;
  endtask

  task automatic goto(input int tt);
    while (tcur != tt) tick();
  endtask

  task automatic drive(input int s);
    sample_in       = 16'(s);
    sample_valid_in = 1'b1;
  endtask

  task automatic wait_start(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!burst_start_out && n < bound);
    chk("start_seen", burst_start_out, 1);
    tcur = 0;
  endtask

  initial begin
    int        exp_ang [5];
    echo_rec_t e;
    exp_ang = '{-30, -10, 10, 30, -30};

    // reset state
    repeat (2) @(negedge clk_in);
    chk("rst_angle", angle_out, 0);
    chk("rst_burst_start", burst_start_out, 0);
    chk("rst_burst_active", burst_active_out, 0);
    chk("rst_listening", listening_out, 0);
    chk("rst_echo_valid", echo_valid_out, 0);
    chk("rst_echo_time", echo_time_out, 0);
    chk("rst_echo_peak", echo_peak_out, 0);
    chk("rst_echo_index", echo_index_out, 0);
    chk("rst_no_echo", no_echo_out, 0);
    chk("rst_scan_done", scan_done_out, 0);

    // sweep, no samples
    rst_n         = 1'b1;
    sweep_mode_in = 1'b1;
    enable_in     = 1'b1;
    threshold_in  = 16'd100;
    wait_start(10);
    for (int p = 0; p < 5; p++) begin
      chk("sw_angle", angle_out, exp_ang[p]);
      chk("sw_burst_active", burst_active_out, 1);
      goto(11);
      chk("sw_listen_t11", listening_out, 0);
      goto(12);
      chk("sw_listen_t12", listening_out, 1);
      chk("sw_burst_off", burst_active_out, 0);
      goto(63);
      chk("sw_no_echo", no_echo_out, 1);
      chk("sw_scan_done", scan_done_out, (p == 3) ? 1 : 0);
      goto(0);
      chk("sw_burst_start", burst_start_out, 1);
      chk("sw_no_echo_pulse", no_echo_out, 0);
      chk("sw_scan_done_pulse", scan_done_out, 0);
    end

    // switch to fixed 15 deg; takes effect next ping
    sweep_mode_in  = 1'b0;
    fixed_angle_in = 8'sd15;
    goto(63);
    goto(0);
    chk("fix_angle", angle_out, 15);
    goto(5);  drive(500);
    goto(6);  sample_valid_in = 1'b0;
    chk("burst_sample_ignored", echo_valid_out, 0);
    goto(10); drive(500);
    goto(11); sample_valid_in = 1'b0;
    chk("blank_sample_ignored", echo_valid_out, 0);
    goto(20); drive(150);
    goto(21); drive(300);
    goto(22); drive(40);
    chk("fix_latency", echo_valid_out, 0);
    goto(23); sample_valid_in = 1'b0;
    e = '{tof: 32'd20, peak: 32'd300, index: 8'd0, angle: 16'd15};
    chk_echo("fix_echo", e);
    goto(24);
    chk("fix_strobe_pulse", echo_valid_out, 0);
    goto(63);
    chk("fix_no_echo", no_echo_out, 0);

    // three crossings, only two reported
    goto(0);
    for (int k = 0; k < 3; k++) begin
      goto(20 + 10 * k); drive(200);
      goto(21 + 10 * k); drive(10);
      goto(22 + 10 * k); sample_valid_in = 1'b0;
      if (k < 2) begin
        e = '{tof: 32'(20 + 10 * k), peak: 32'd200, index: 8'(k), angle: 16'd15};
        chk_echo("multi_echo", e);
      end else begin
        chk("multi_capped", echo_valid_out, 0);
        chk("multi_hold_time", echo_time_out, 30);
      end
    end
    goto(63);
    chk("multi_no_echo", no_echo_out, 0);

    // open echo at period end is force-emitted
    goto(0);
    goto(60); drive(200);
    goto(61); drive(250);
    goto(62); sample_valid_in = 1'b0;
    chk("force_not_yet", echo_valid_out, 0);
    goto(63);
    e = '{tof: 32'd60, peak: 32'd250, index: 8'd0, angle: 16'd15};
    chk_echo("force_echo", e);
    chk("force_no_echo", no_echo_out, 0);
    goto(0);
    chk("force_strobe_pulse", echo_valid_out, 0);
    chk("force_hold_time", echo_time_out, 60);

    // enable dropped mid-ping: ping completes, then IDLE
    goto(30);
    enable_in = 1'b0;
    goto(63);
    chk("drop_still_listening", listening_out, 1);
    tick();
    chk("drop_idle_listen", listening_out, 0);
    chk("drop_idle_burst", burst_active_out, 0);
    chk("drop_idle_start", burst_start_out, 0);
    repeat (5) tick();
    chk("drop_idle_hold", burst_active_out, 0);

    // reset mid-ping clears outputs at once
    enable_in = 1'b1;
    wait_start(10);
    goto(30);
    chk("pre_rst_listen", listening_out, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_angle", angle_out, 0);
    chk("midrst_listen", listening_out, 0);
    chk("midrst_burst", burst_active_out, 0);
    chk("midrst_echo_time", echo_time_out, 0);
    chk("midrst_echo_peak", echo_peak_out, 0);
    chk("midrst_echo_valid", echo_valid_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sonar_ping_sequencer.md
# sonar_ping_sequencer

Parametrised ping sequencer for the sonar array: it schedules transmit bursts, steps the beam angle through a configurable sweep or holds a fixed angle, and gates a blanking/listen window. During the listen window it detects up to `MAX_ECHOES` echoes per ping from the receive-beamformed magnitude stream, using threshold hysteresis. It sits between the transmit/receive beamformers and the time-of-flight/display path. It replaces the single fixed-angle, single-echo burst/threshold logic.

## Interface
Parameters:
- `PERIOD_CYCLES`, 16777216: ping period in clocks.
- `BURST_CYCLES`, 524288: transmit burst length in clocks.
- `BLANK_CYCLES`, 65536: post-burst ringdown blanking in clocks.
- `ANGLE_WIDTH`, 8: signed beam-angle width, in degrees.
- `NUM_ANGLES`, 7: number of sweep steps.
- `ANGLE_START`, -30: first sweep angle.
- `ANGLE_STEP`, 10: sweep increment.
- `SAMPLE_WIDTH`, 16: unsigned magnitude width.
- `MAX_ECHOES`, 4: echoes reported per ping.
- `TW`, `$clog2(PERIOD_CYCLES)`: time field width (derived).

Ports:
- `clk_in`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable_in`, in, 1: run pings.
- `sweep_mode_in`, in, 1: 1 = sweep, 0 = fixed angle.
- `fixed_angle_in`, in, `ANGLE_WIDTH`, signed: angle used in fixed mode.
- `threshold_in`, in, `SAMPLE_WIDTH`: echo detect threshold.
- `sample_in`, in, `SAMPLE_WIDTH`: aggregated waveform magnitude.
- `sample_valid_in`, in, 1: sample strobe.
- `angle_out`, out, `ANGLE_WIDTH`, signed: current beam angle.
- `burst_start_out`, out, 1: one-cycle pulse at the start of each ping.
- `burst_active_out`, out, 1: transmit gate.
- `listening_out`, out, 1: listen window active.
- `echo_valid_out`, out, 1: echo record strobe.
- `echo_index_out`, out, `$clog2(MAX_ECHOES)`: echo number within the ping.
- `echo_time_out`, out, `TW`: clocks from burst start to the rising crossing.
- `echo_peak_out`, out, `SAMPLE_WIDTH`: peak magnitude of the echo.
- `echo_angle_out`, out, `ANGLE_WIDTH`: angle of the ping.
- `no_echo_out`, out, 1: pulse at period end when the ping produced zero echoes.
- `scan_done_out`, out, 1: pulse at the end of the last sweep step.

## Operation
- States: `IDLE`, `BURST`, `BLANK`, `LISTEN`.
- `IDLE` goes to `BURST` when `enable_in` is high. On that transition: `timer` = 0, `burst_start_out` = 1, and mode and angle are latched for the ping.
- `timer` increments every cycle in the non-IDLE states.
  - `BURST` → `BLANK` at `timer == BURST_CYCLES-1`.
  - `BLANK` → `LISTEN` at `timer == BURST_CYCLES+BLANK_CYCLES-1`.
  - `LISTEN` ends at `timer == PERIOD_CYCLES-1` (the period end).
- At period end:
  - If `enable_in` is high, go directly to `BURST` with `timer` = 0 and a new `burst_start_out`.
  - Otherwise go to `IDLE`. Deasserting `enable_in` never truncates a ping.
- Angle:
  - Sweep mode: `angle_out = ANGLE_START + idx*ANGLE_STEP`. `idx` advances at period end and wraps from `NUM_ANGLES-1` to 0; the wrap ping also asserts `scan_done_out`.
  - Fixed mode: `angle_out` = latched `fixed_angle_in`, and `idx` holds.
  - A mode change takes effect at the next ping. Entering sweep mode from `IDLE` or from fixed mode restarts at `idx` = 0.
- Echo tracker (samples are used only when `listening_out` and `sample_valid_in` are both high):
  - Armed: when `sample_in > threshold_in`, record `time = timer` and `peak = sample_in`, then go to Open.
  - Open: `peak = max(peak, sample_in)`. When `sample_in <= threshold_in>>1`, emit the echo and return to Armed.
  - Open at period end: emit on the period-end cycle with the current peak.
  - After `MAX_ECHOES` emits, further crossings are ignored until the next ping.
- `no_echo_out` pulses on the period-end cycle when the echo count is 0. If an open echo is force-emitted on that cycle, the count is 1, so `no_echo_out` stays 0.

## Timing
- Reset values: state `IDLE`, `timer` 0, `idx` 0, `angle_out` 0. All strobes are 0, `burst_active_out` 0, `listening_out` 0, and all echo fields are 0.
- `burst_active_out` and `listening_out` are registered and exactly match their states, so the first `listening_out` cycle has `timer == BURST_CYCLES+BLANK_CYCLES`.
- Echo strobe latency is 1 clock after the releasing sample. Echo fields hold until the next strobe.
- `echo_angle_out` equals `angle_out` of the ping the echo belongs to, even when the strobe lands on the period-end cycle.
- `burst_start_out`, `scan_done_out` and `no_echo_out` are single-cycle pulses. `scan_done_out` and `no_echo_out` may coincide.
- Reset asserted mid-ping: all outputs clear asynchronously and nothing is emitted.

## Structure
- Shared package `sonar_pkg`: the state enum `ping_state_t` and the struct `echo_rec_t` (time, peak, index, angle).
- Sub-module `echo_tracker`: hysteresis, peak hold, echo count and force-emit. Interface: sample, valid, threshold, window, flush, ping start.

## Test plan
Small bench parameters: `PERIOD_CYCLES`=64, `BURST_CYCLES`=8, `BLANK_CYCLES`=4, `NUM_ANGLES`=4, `ANGLE_START`=-30, `ANGLE_STEP`=20, `MAX_ECHOES`=2.
- Sweep, `enable_in` held high, no samples → `angle_out` is -30, -10, 10, 30, -30. Each ping gives `no_echo_out` at `timer` 63, and `scan_done_out` accompanies the 30° ping's end.
- Fixed mode at 15°, threshold 100. Samples of 150 at `timer` 20, 300 at 21 and 40 at 22 → echo with time 20, peak 300, index 0 and angle 15, strobed 1 clock after the `timer` 22 sample.
- Sample 500 at `timer` 5 (during burst) and at `timer` 10 (during blank) → no echo is reported.
- Three separated crossings in one ping → only indices 0 and 1 are emitted and `no_echo_out` stays 0.
- Crossing at `timer` 60 with no release → force-emitted on the `timer` 63 cycle with time 60.
- `enable_in` dropped at `timer` 30 → the ping completes and the block goes to `IDLE` at 64. Separately, `rst_n` low at `timer` 30 → all outputs are 0 immediately.
